// File: rtl/bp_cfg_seq_loader.sv
`default_nettype none
//----------------------------------------------------------------------
// bp_cfg_seq_loader: replays a programmable (bcast, core, addr, data)
// table as cfg-bus writes, with optional per-write readback verify.
// Revision: 1.0
//----------------------------------------------------------------------
module bp_cfg_seq_loader #(
    parameter int num_core_p       = 4,
    parameter int cfg_core_width_p = 8,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int els_p            = 16,
    localparam int lg_els_lp       = $clog2(els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        prog_v_i,
    input  logic [lg_els_lp-1:0]        prog_idx_i,
    input  logic                        prog_bcast_i,
    input  logic [cfg_core_width_p-1:0] prog_core_i,
    input  logic [cfg_addr_width_p-1:0] prog_addr_i,
    input  logic [cfg_data_width_p-1:0] prog_data_i,

    input  logic [lg_els_lp:0]          count_i,
    input  logic                        verify_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [lg_els_lp-1:0]        err_idx_o,

    output logic                        cfg_v_o,
    output logic                        cfg_w_o,
    output logic [cfg_core_width_p-1:0] cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ready_i,
    input  logic                        cfg_rdata_v_i,
    input  logic [cfg_data_width_p-1:0] cfg_rdata_i
);

    localparam logic [lg_els_lp:0]          els_lp       = (lg_els_lp+1)'(els_p);
    localparam logic [cfg_core_width_p-1:0] last_core_lp = cfg_core_width_p'(num_core_p - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_ADV     = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e                        state_q, state_d;
    logic [lg_els_lp:0]            idx_q, idx_d;
    logic [lg_els_lp:0]            count_q, count_d;
    logic [cfg_core_width_p-1:0]   core_cnt_q, core_cnt_d;
    logic                          verify_q, verify_d;
    logic                          err_q, err_d;
    logic [lg_els_lp-1:0]          err_idx_q, err_idx_d;

    logic                          tbl_bcast_q [els_p];
    logic [cfg_core_width_p-1:0]   tbl_core_q  [els_p];
    logic [cfg_addr_width_p-1:0]   tbl_addr_q  [els_p];
    logic [cfg_data_width_p-1:0]   tbl_data_q  [els_p];

    logic                          tbl_we;
    logic [lg_els_lp-1:0]          ent_idx;
    logic                          cur_bcast;
    logic [cfg_core_width_p-1:0]   cur_core;
    logic [lg_els_lp:0]            count_clamped;
    logic [lg_els_lp:0]            idx_inc;

    assign tbl_we        = prog_v_i && (state_q == S_IDLE) && ({1'b0, prog_idx_i} < els_lp);
    assign ent_idx       = idx_q[lg_els_lp-1:0];
    assign cur_bcast     = tbl_bcast_q[ent_idx];
    assign cur_core      = cur_bcast ? core_cnt_q : tbl_core_q[ent_idx];
    assign count_clamped = (count_i > els_lp) ? els_lp : count_i;
    assign idx_inc       = idx_q + 1'b1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                tbl_bcast_q[i] <= 1'b0;
                tbl_core_q[i]  <= '0;
                tbl_addr_q[i]  <= '0;
                tbl_data_q[i]  <= '0;
            end
        end else if (tbl_we) begin
            tbl_bcast_q[prog_idx_i] <= prog_bcast_i;
            tbl_core_q[prog_idx_i]  <= prog_core_i;
            tbl_addr_q[prog_idx_i]  <= prog_addr_i;
            tbl_data_q[prog_idx_i]  <= prog_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            core_cnt_q <= '0;
            verify_q   <= 1'b0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            core_cnt_q <= core_cnt_d;
            verify_q   <= verify_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
        end
    end

    // Request fields are driven only in the issuing states so the bus idles at zero.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        core_cnt_d = core_cnt_q;
        verify_d   = verify_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;
        cfg_v_o    = 1'b0;
        cfg_w_o    = 1'b0;
        cfg_core_o = '0;
        cfg_addr_o = '0;
        cfg_data_o = '0;
        done_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d    = count_clamped;
                    verify_d   = verify_i;
                    err_d      = 1'b0;
                    err_idx_d  = '0;
                    idx_d      = '0;
                    core_cnt_d = '0;
                    state_d    = (count_clamped == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                cfg_v_o    = 1'b1;
                cfg_w_o    = 1'b1;
                cfg_core_o = cur_core;
                cfg_addr_o = tbl_addr_q[ent_idx];
                cfg_data_o = tbl_data_q[ent_idx];
                if (cfg_ready_i) begin
                    state_d = verify_q ? S_RD_REQ : S_ADV;
                end
            end
            S_RD_REQ: begin
                cfg_v_o    = 1'b1;
                cfg_core_o = cur_core;
                cfg_addr_o = tbl_addr_q[ent_idx];
                if (cfg_ready_i) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (cfg_rdata_v_i) begin
                    if ((cfg_rdata_i != tbl_data_q[ent_idx]) && !err_q) begin
                        err_d     = 1'b1;
                        err_idx_d = ent_idx;
                    end
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                if (cur_bcast && (core_cnt_q < last_core_lp)) begin
                    core_cnt_d = core_cnt_q + 1'b1;
                    state_d    = S_REQ;
                end else begin
                    core_cnt_d = '0;
                    idx_d      = idx_inc;
                    state_d    = (idx_inc == count_q) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cfg_seq_loader.sv
`default_nettype none
//----------------------------------------------------------------------
// tb_bp_cfg_seq_loader: randomized scoreboard bench for bp_cfg_seq_loader.
// Revision: 1.0
//----------------------------------------------------------------------
module tb_bp_cfg_seq_loader;

    localparam int NC  = 4;
    localparam int CW  = 8;
    localparam int AW  = 16;
    localparam int DW  = 64;
    localparam int ELS = 16;
    localparam int LG  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          prog_v = 1'b0;
    logic [LG-1:0] prog_idx = '0;
    logic          prog_bcast = 1'b0;
    logic [CW-1:0] prog_core = '0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic [LG:0]   count = '0;
    logic          verify = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, err;
    logic [LG-1:0] err_idx;
    logic          cfg_v, cfg_w;
    logic [CW-1:0] cfg_core;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready = 1'b0;
    logic          rdata_v = 1'b0;
    logic [DW-1:0] rdata = '0;

    bp_cfg_seq_loader #(
        .num_core_p(NC), .cfg_core_width_p(CW), .cfg_addr_width_p(AW),
        .cfg_data_width_p(DW), .els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .prog_v_i(prog_v), .prog_idx_i(prog_idx), .prog_bcast_i(prog_bcast),
        .prog_core_i(prog_core), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
        .count_i(count), .verify_i(verify), .start_i(start),
        .busy_o(busy), .done_o(done), .err_o(err), .err_idx_o(err_idx),
        .cfg_v_o(cfg_v), .cfg_w_o(cfg_w), .cfg_core_o(cfg_core),
        .cfg_addr_o(cfg_addr), .cfg_data_o(cfg_data), .cfg_ready_i(cfg_ready),
        .cfg_rdata_v_i(rdata_v), .cfg_rdata_i(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            w;
        logic [CW-1:0] core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            bad;
    } req_t;

    req_t          exp_q[$];
    logic [DW-1:0] rsp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference view of the table and which entries the responder corrupts.
    bit            m_bcast [ELS];
    logic [CW-1:0] m_core  [ELS];
    logic [AW-1:0] m_addr  [ELS];
    logic [DW-1:0] m_data  [ELS];
    bit            bad_ent [ELS];
    bit            exp_err;
    int            exp_err_idx;

    int ready_mode = 0;
    int acc_cnt = 0;
    int v_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       cfg_ready = 1'b1;
            1:       cfg_ready = 1'($urandom_range(0, 1));
            default: cfg_ready = 1'b0;
        endcase
    end

    // Read responder: returns queued data after a random delay, plus stray pulses while no read is pending.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            rdata_v = 1'b0;
        end else if (rsp_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            rdata_v = 1'b1;
            rdata   = rsp_q.pop_front();
        end else if (rsp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
            rdata_v = 1'b1;
            rdata   = {$urandom, $urandom};
        end else begin
            rdata_v = 1'b0;
            rdata   = {$urandom, $urandom};
        end
    end

    bit            stall_p = 1'b0;
    logic          p_w;
    logic [CW-1:0] p_core;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;

    always @(negedge clk) begin
        if (!reset_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("stall_v", cfg_v, 1);
                chk("stall_w", cfg_w, p_w);
                chk("stall_core", cfg_core, p_core);
                chk("stall_addr", cfg_addr, p_addr);
                chk("stall_data", cfg_data, p_data);
            end
            if (cfg_v) v_cnt++;
            if (cfg_v && cfg_ready) begin
                acc_cnt++;
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    req_t e;
                    e = exp_q.pop_front();
                    chk("req_w", cfg_w, e.w);
                    chk("req_core", cfg_core, e.core);
                    chk("req_addr", cfg_addr, e.addr);
                    if (e.w) chk("req_data", cfg_data, e.data);
                    else     rsp_q.push_back(e.bad ? (e.data ^ 64'h1) : e.data);
                end
            end
            stall_p = cfg_v && !cfg_ready;
            p_w = cfg_w; p_core = cfg_core; p_addr = cfg_addr; p_data = cfg_data;
        end
    end

    task automatic prog(input int idx, input bit b, input logic [CW-1:0] c,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        prog_v = 1'b1; prog_idx = LG'(idx); prog_bcast = b;
        prog_core = c; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_v = 1'b0;
        m_bcast[idx] = b; m_core[idx] = c; m_addr[idx] = a; m_data[idx] = d;
    endtask

    task automatic build_exp(input int cnt, input bit ver);
        int n;
        n = (cnt > ELS) ? ELS : cnt;
        exp_err = 1'b0;
        exp_err_idx = 0;
        for (int i = 0; i < n; i++) begin
            int nc;
            nc = m_bcast[i] ? NC : 1;
            for (int c = 0; c < nc; c++) begin
                req_t r;
                r.core = m_bcast[i] ? CW'(c) : m_core[i];
                r.addr = m_addr[i];
                r.data = m_data[i];
                r.w = 1'b1; r.bad = 1'b0;
                exp_q.push_back(r);
                if (ver) begin
                    r.w = 1'b0; r.bad = bad_ent[i];
                    exp_q.push_back(r);
                    if (bad_ent[i] && !exp_err) begin
                        exp_err = 1'b1;
                        exp_err_idx = i;
                    end
                end
            end
        end
    endtask

    task automatic run_seq(input int cnt, input bit ver, input bit first_chk,
                           input bit disturb, output int waited);
        bit seen;
        build_exp(cnt, ver);
        @(posedge clk); #1;
        count = (LG+1)'(cnt); verify = ver; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; count = (LG+1)'($urandom); verify = 1'($urandom);
        if (first_chk) begin
            @(negedge clk);
            chk("v_cycle_after_start", cfg_v, 1);
        end
        if (disturb) begin
            @(posedge clk); #1;
            start = 1'b1; count = 5'd1;
            prog_v = 1'b1; prog_idx = '0; prog_bcast = ~m_bcast[0];
            prog_core = ~m_core[0]; prog_addr = ~m_addr[0]; prog_data = ~m_data[0];
            @(posedge clk); #1;
            start = 1'b0; prog_v = 1'b0;
        end
        waited = 0;
        seen = 1'b0;
        while (waited < 5000) begin
            @(negedge clk);
            waited++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        chk("err_o", err, exp_err);
        if (exp_err) chk("err_idx", err_idx, LG'(exp_err_idx));
        chk("all_reqs_issued", exp_q.size(), 0);
        chk("rsp_drained", rsp_q.size(), 0);
        exp_q.delete();
        rsp_q.delete();
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, a0, v0;
        for (int i = 0; i < ELS; i++) begin
            m_bcast[i] = 0; m_core[i] = '0; m_addr[i] = '0; m_data[i] = '0; bad_ent[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_err", err, 0);       chk("rst_err_idx", err_idx, 0);
        chk("rst_cfg_v", cfg_v, 0);   chk("rst_cfg_w", cfg_w, 0);
        chk("rst_core", cfg_core, 0); chk("rst_addr", cfg_addr, 0);
        chk("rst_data", cfg_data, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Three unicast writes in table order.
        prog(0, 0, 8'd1, 16'h10, 64'hA);
        prog(1, 0, 8'd2, 16'h20, 64'hB);
        prog(2, 0, 8'd0, 16'h30, 64'hC);
        ready_mode = 0;
        a0 = acc_cnt;
        run_seq(3, 0, 1, 0, w);
        chk("t1_accepts", acc_cnt - a0, 3);

        // Broadcast entry under random back-pressure.
        prog(0, 1, 8'h55, 16'h4, 64'h1);
        ready_mode = 1;
        a0 = acc_cnt;
        run_seq(1, 0, 0, 0, w);
        chk("t2_accepts", acc_cnt - a0, 4);

        // Verify with a bad readback on entry 1 only.
        prog(0, 0, 8'd1, 16'h10, 64'hA);
        prog(1, 0, 8'd2, 16'h20, 64'hB);
        bad_ent[1] = 1;
        a0 = acc_cnt;
        run_seq(2, 1, 0, 0, w);
        chk("t3_accepts", acc_cnt - a0, 4);
        bad_ent[1] = 0;

        // Empty sequence.
        v0 = v_cnt;
        run_seq(0, 0, 0, 0, w);
        chk("t4_no_cfg_v", v_cnt - v0, 0);
        chk("t4_done_latency_le2", w <= 2, 1);

        // Start and program attempts while busy must not disturb anything.
        prog(0, 1, 8'h09, 16'h1234, 64'hDEAD_BEEF);
        prog(1, 0, 8'h03, 16'h5678, 64'h0123_4567_89AB_CDEF);
        ready_mode = 1;
        run_seq(2, 1, 0, 1, w);
        run_seq(2, 0, 0, 0, w);

        // Randomized tables, counts (including clamp), verify and corruption.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < ELS; i++) begin
                if ($urandom_range(0, 1) == 1)
                    prog(i, ($urandom_range(0, 3) == 0), CW'($urandom), AW'($urandom), {$urandom, $urandom});
                bad_ent[i] = ($urandom_range(0, 3) == 0);
            end
            ready_mode = $urandom_range(0, 1);
            run_seq($urandom_range(0, 20), 1'($urandom_range(0, 1)), 0, 0, w);
        end
        for (int i = 0; i < ELS; i++) bad_ent[i] = 0;

        // Reset while a request is stalled.
        prog(0, 0, 8'd3, 16'h77, 64'h1234);
        ready_mode = 2;
        @(posedge clk); #1;
        count = 5'd1; verify = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        chk("pre_reset_v", cfg_v, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cfg_v", cfg_v, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);   chk("mid_rst_err", err, 0);
        chk("mid_rst_core", cfg_core, 0); chk("mid_rst_addr", cfg_addr, 0);
        chk("mid_rst_data", cfg_data, 0); chk("mid_rst_w", cfg_w, 0);
        exp_q.delete();
        rsp_q.delete();
        for (int i = 0; i < ELS; i++) begin
            m_bcast[i] = 0; m_core[i] = '0; m_addr[i] = '0; m_data[i] = '0;
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        ready_mode = 0;
        a0 = acc_cnt;
        run_seq(2, 1, 0, 0, w);
        chk("t6_accepts", acc_cnt - a0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
